// File: rtl/cmp_share_ctrl.sv
// rtl/cmp_share_ctrl.sv - round-robin sharing of one compare unit between two requesters
// Optional per-requester accept counters enabled by defining CMP_STATS_EN.
module cmp_share_ctrl #(
  parameter int W     = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [W-1:0]     r0_a,
  input  logic [W-1:0]     r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [W-1:0]     r1_a,
  input  logic [W-1:0]     r1_b,
  output logic [W-1:0]     cmp_a,
  output logic [W-1:0]     cmp_b,
  input  logic [W-1:0]     cmp_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [2:0]       rsp_code,
  output logic             rsp_err,
`ifdef CMP_STATS_EN
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_cnt0,
  output logic [CNT_W-1:0] stat_cnt1,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   grant0;
  logic   grant1;
  logic   code_ok;
  logic   unused_res;

  // Tie goes to whoever did not win last; grants only exist in IDLE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = r0_valid && (!r1_valid || last_grant);
      grant1 = r1_valid && (!r0_valid || !last_grant);
    end
  end

  // Ready ports are forced low while reset is held so nothing looks accepted.
  assign r0_ready = grant0 & rst_n;
  assign r1_ready = grant1 & rst_n;

  assign code_ok    = (cmp_res[2:0] == 3'b001) || (cmp_res[2:0] == 3'b010) ||
                      (cmp_res[2:0] == 3'b100);
  assign unused_res = ^cmp_res[W-1:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cmp_a      <= '0;
      cmp_b      <= '0;
      rsp_id     <= 1'b0;
      rsp_code   <= 3'b000;
      rsp_err    <= 1'b0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            cmp_a      <= grant1 ? r1_a : r0_a;
            cmp_b      <= grant1 ? r1_b : r0_b;
            rsp_id     <= grant1;
            last_grant <= grant1;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_code  <= cmp_res[2:0];
          rsp_err   <= !code_ok;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef CMP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else if (stat_clr) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else begin
      if (grant0 && (stat_cnt0 != {CNT_W{1'b1}}))
        stat_cnt0 <= stat_cnt0 + 1'b1;
      if (grant1 && (stat_cnt1 != {CNT_W{1'b1}}))
        stat_cnt1 <= stat_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// tb/tb_cmp_share_ctrl.sv - randomized bench for cmp_share_ctrl against a behavioural model
module tb_cmp_share_ctrl;
  localparam int W     = 64;
  localparam int CNT_W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_valid, r1_valid;
  logic          r0_ready, r1_ready;
  logic [W-1:0]  r0_a, r0_b, r1_a, r1_b;
  logic [W-1:0]  cmp_a, cmp_b, cmp_res;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [2:0]    rsp_code;
  logic          force_en;
  logic [2:0]    force_code;
`ifdef CMP_STATS_EN
  logic             stat_clr;
  logic [CNT_W-1:0] stat_cnt0, stat_cnt1;
`endif

  always #5 clk = ~clk;

  cmp_share_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_res(cmp_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_code(rsp_code), .rsp_err(rsp_err),
`ifdef CMP_STATS_EN
    .stat_clr(stat_clr), .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1),
`endif
    .busy(busy)
  );

  // Comparator model: true one-hot compare unless a forced (possibly bad) code is injected.
  function automatic logic [W-1:0] cmp_fn(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a < b) return 64'd1;
    if (a > b) return 64'd2;
    return 64'd4;
  endfunction

  assign cmp_res = force_en ? {{(W-3){1'b0}}, force_code} : cmp_fn(cmp_a, cmp_b);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: pipeline position of the single outstanding operation.
  int           m_phase;     // 0 = nothing in flight, 1 = compare this cycle, 2 = response pending
  bit           m_last;
  bit           m_id;
  logic [W-1:0] m_a, m_b;
  logic [2:0]   m_code;
  bit           m_err;
  int           n_acc0, n_acc1;

  task automatic model_reset();
    m_phase = 0; m_last = 1'b1; m_id = 1'b0;
    m_a = '0; m_b = '0; m_code = 3'b000; m_err = 1'b0;
    n_acc0 = 0; n_acc1 = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_rsp_valid"}, rsp_valid, (m_phase == 2));
    check({pfx, "_busy"}, busy, (m_phase != 0));
    check({pfx, "_rsp_id"}, rsp_id, m_id);
    check({pfx, "_rsp_code"}, rsp_code, m_code);
    check({pfx, "_rsp_err"}, rsp_err, m_err);
    check({pfx, "_cmp_a"}, cmp_a, m_a);
    check({pfx, "_cmp_b"}, cmp_b, m_b);
  endtask

  // Called at a negedge with inputs applied; checks readies, advances one clock, checks outputs.
  task automatic cycle(input string pfx, output bit acc0, output bit acc1);
    bit           e0, e1;
    logic [W-1:0] full;
    logic [2:0]   c;
    #1;
    e0 = 1'b0; e1 = 1'b0;
    if (m_phase == 0) begin
      if (r0_valid && r1_valid) begin
        e0 = m_last; e1 = !m_last;
      end else begin
        e0 = r0_valid; e1 = r1_valid;
      end
    end
    check({pfx, "_r0_ready"}, r0_ready, e0);
    check({pfx, "_r1_ready"}, r1_ready, e1);
    acc0 = e0; acc1 = e1;
    if (m_phase == 0) begin
      if (e0 || e1) begin
        m_id = e1; m_last = e1;
        m_a = e1 ? r1_a : r0_a;
        m_b = e1 ? r1_b : r0_b;
        if (e1) n_acc1++; else n_acc0++;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      full = cmp_fn(m_a, m_b);
      c = force_en ? force_code : full[2:0];
      m_code = c;
      m_err = ($countones(c) != 1);
      m_phase = 2;
    end else if (rsp_ready) begin
      m_phase = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(pfx);
  endtask

  task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit fen, input logic [2:0] fc,
                        input logic [2:0] exp_code, input bit exp_err);
    bit a0, a1;
    r0_valid = !id; r1_valid = id;
    if (id) begin r1_a = a; r1_b = b; end else begin r0_a = a; r0_b = b; end
    force_en = fen; force_code = fc; rsp_ready = 1'b1;
    cycle("dir_acc", a0, a1);
    check("dir_accept", {a1, a0}, id ? 2'b10 : 2'b01);
    r0_valid = 1'b0; r1_valid = 1'b0;
    cycle("dir_exec", a0, a1);
    check("dir_valid", rsp_valid, 1'b1);
    check("dir_id", rsp_id, id);
    check("dir_code", rsp_code, exp_code);
    check("dir_err", rsp_err, exp_err);
    cycle("dir_resp", a0, a1);
  endtask

  initial begin
    bit a0, a1, p0, p1;
    int grants_id[$];
    int grants_t[$];
    int waited;

    rst_n = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    force_en = 1'b0; force_code = 3'b000;
`ifdef CMP_STATS_EN
    stat_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_r0_ready", r0_ready, 1'b0);
    check("rst_r1_ready", r1_ready, 1'b0);
    check_outputs("rst");
    r0_valid = 1'b0; r1_valid = 1'b0;
    rst_n = 1'b1;

    // Directed single requests and error-code classification.
    run_op(1'b0, 64'd5, 64'd9, 1'b0, 3'b000, 3'b001, 1'b0);
    run_op(1'b1, 64'd7, 64'd7, 1'b0, 3'b000, 3'b100, 1'b0);
    run_op(1'b0, 64'd1, 64'd2, 1'b1, 3'b000, 3'b000, 1'b1);
    run_op(1'b1, 64'd3, 64'd2, 1'b1, 3'b110, 3'b110, 1'b1);
    run_op(1'b0, 64'd9, 64'd3, 1'b0, 3'b000, 3'b010, 1'b0);

    // Randomized traffic honouring the hold-until-accepted contract.
    p0 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!r0_valid || p0) begin
        r0_valid = $urandom_range(1, 0);
        r0_a = {$urandom, $urandom};
        r0_b = ($urandom_range(3, 0) == 0) ? r0_a : {$urandom, $urandom};
      end
      if (!r1_valid || p1) begin
        r1_valid = $urandom_range(1, 0);
        r1_a = {$urandom, $urandom};
        r1_b = ($urandom_range(3, 0) == 0) ? r1_a : {$urandom, $urandom};
      end
      rsp_ready  = ($urandom_range(9, 0) < 6);
      force_en   = ($urandom_range(5, 0) == 0);
      force_code = 3'($urandom);
      cycle("rnd", p0, p1);
    end

    // Reset in the middle of a compare.
    r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b1; force_en = 1'b0;
    waited = 0;
    while (m_phase != 1 && waited < 10) begin
      cycle("pre_rst", a0, a1);
      waited++;
    end
    check("reach_exec", (m_phase == 1), 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_r0_ready", r0_ready, 1'b0);
    check("mid_rst_r1_ready", r1_ready, 1'b0);
    check_outputs("mid_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Held tie after reset: strict alternation starting with requester 0, one grant per 3 cycles.
    for (int t = 0; t < 12; t++) begin
      cycle("tie", a0, a1);
      if (a0 || a1) begin
        grants_id.push_back(a1 ? 1 : 0);
        grants_t.push_back(t);
        r0_a = {$urandom, $urandom}; r0_b = {$urandom, $urandom};
        r1_a = {$urandom, $urandom}; r1_b = {$urandom, $urandom};
      end
    end
    check("tie_grant_count", grants_id.size(), 4);
    for (int g = 0; g < grants_id.size() && g < 4; g++) begin
      check("tie_grant_id", grants_id[g], g % 2);
      check("tie_grant_time", grants_t[g], 3 * g);
    end

`ifdef CMP_STATS_EN
    r0_valid = 1'b0; r1_valid = 1'b0;
    check("stat_cnt0", stat_cnt0, (n_acc0 > (2**CNT_W - 1)) ? (2**CNT_W - 1) : n_acc0);
    check("stat_cnt1", stat_cnt1, (n_acc1 > (2**CNT_W - 1)) ? (2**CNT_W - 1) : n_acc1);
    stat_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stat_clr = 1'b0;
    check("stat_clr0", stat_cnt0, 0);
    check("stat_clr1", stat_cnt1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cmp_share_ctrl.md
Name: cmp_share_ctrl

Overview:
- Sequences and time-shares the single 64-bit compare unit (subtract-based, one-hot result: 1 = A<B, 2 = A>B, 4 = A==B) between two ALU-side requesters: requester 0 (branch resolve) and requester 1 (set-less-than/compare ops).
- Round-robin arbitration, operand registering, result capture, and one response channel with valid/ready handshake.
- Sits between the EX-stage requesters and the shared comparator instance.

Parameters:
- W, 64, operand width driven to the comparator.
- CNT_W, 16, width of the per-requester statistics counters (used only with CMP_STATS_EN).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- r0_valid  input  1  requester 0 has a compare pending.
- r0_ready  output  1  requester 0 request accepted this cycle.
- r0_a  input  W  requester 0 operand A.
- r0_b  input  W  requester 0 operand B.
- r1_valid  input  1  requester 1 has a compare pending.
- r1_ready  output  1  requester 1 request accepted this cycle.
- r1_a  input  W  requester 1 operand A.
- r1_b  input  W  requester 1 operand B.
- cmp_a  output  W  registered operand A to comparator.
- cmp_b  output  W  registered operand B to comparator.
- cmp_res  input  W  comparator result; only bits [2:0] are meaningful.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester that owns the response.
- rsp_code  output  3  captured cmp_res[2:0].
- rsp_err  output  1  captured code was not exactly one-hot.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cmp_a, cmp_b, rsp_code = 0; rsp_valid, rsp_err, rsp_id, r0_ready, r1_ready, busy = 0; last_grant=1, so requester 0 wins the first tie.
- FSM has three states:
  - IDLE to EXEC: on any rX_valid, when a transfer occurs.
  - EXEC to RESP: unconditional, one cycle.
  - RESP to IDLE: on rsp_valid && rsp_ready.
- IDLE arbitration (combinational ready):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester != last_grant gets ready=1.
  - At most one rX_ready is high, and never outside IDLE.
- Transfer (rX_valid && rX_ready at edge): latch rX_a/rX_b into cmp_a/cmp_b, owner into rsp_id, last_grant=owner.
- Requester contract: hold valid and operands stable until accepted. The controller never drops a request that is valid and unaccepted.
- EXEC: cmp_a/cmp_b are stable all cycle; the comparator is combinational.
  - At the end of EXEC, capture rsp_code=cmp_res[2:0].
  - rsp_err=1 unless rsp_code is one of 3'b001, 3'b010, 3'b100. This includes code 0.
- RESP: rsp_valid=1 and rsp_id/rsp_code/rsp_err are held stable until rsp_ready. rsp_valid deasserts on the cycle after the handshake edge.
- Latency: accept edge N, capture edge N+1, rsp_valid high from N+1 to N+2 (first cycle visible after edge N+1).
  - With rsp_ready tied high, the earliest next accept is edge N+3.
  - Peak rate is one compare per 3 cycles.
- cmp_a/cmp_b hold their last values outside transfers and do not return to 0.
- rsp_valid in IDLE/EXEC is 0. New requests are not accepted while in RESP: no overlap, no skid.
- Reset mid-EXEC or mid-RESP: the operation is discarded, no response is produced, and requesters must re-present.
- Simultaneous r0/r1 valid on consecutive opportunities: grants strictly alternate.

Optional Feature:
- CMP_STATS_EN:
  - When defined, adds output ports stat_cnt0 and stat_cnt1 (CNT_W each) plus input stat_clr (1).
  - stat_cntX increments on each accepted request from requester X and saturates at all-ones.
  - stat_clr=1 zeros both counters synchronously; it takes priority over increment.
  - Both counters reset to 0 asynchronously.
- When not defined: no extra ports and no counter logic. Behaviour is otherwise identical.

Test Plan:
- Single request: r0_valid=1, a=5, b=9, comparator model returns 1 → r0_ready at cycle 0, rsp_valid at cycle 2 with rsp_id=0, rsp_code=3'b001, rsp_err=0, busy=1 cycles 1–2.
- Tie: r0 and r1 both valid from reset, held, rsp_ready=1 → grant order 0, 1, 0, 1; each accepted 3 cycles apart; cmp_a/cmp_b match the granted operands.
- Backpressure: rsp_ready=0 for 5 cycles with r1 pending → rsp_valid and rsp_code held constant; r1_ready stays 0; r1 accepted the cycle after the handshake.
- Bad code: comparator model returns 3'b000, then 3'b110 → rsp_err=1 for both; equal operands returning 3'b100 → rsp_err=0.
- Reset mid-op: assert rst_n=0 during EXEC → all outputs 0 immediately (async); after release, no stale rsp_valid; r0 wins the next tie.
- CMP_STATS_EN: 3 r0 and 2 r1 accepts → stat_cnt0=3, stat_cnt1=2; stat_clr pulse → 0. With CNT_W=2, 5 accepts → saturates at 3.
